// File: rtl/health_bar_ctrl.sv
// health_bar_ctrl: round/health sequencer for the two on-screen health bars.
// Holds each player's HP, animates the displayed fill toward HP once per frame,
// declares KO, and maps DrawX/DrawY onto bar sprite coordinates with a fill flag.
module health_bar_ctrl #(
    parameter int unsigned HP_MAX   = 100,
    parameter int unsigned DMG      = 25,
    parameter int unsigned FILL_STP = 2,
    parameter int unsigned DRN_STP  = 1,
    parameter int unsigned P1_X     = 16,
    parameter int unsigned P2_X     = 480,
    parameter int unsigned BAR_Y    = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       round_start,
    input  logic       hit_p1,
    input  logic       hit_p2,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       hit_ack_p1,
    output logic       hit_ack_p2,
    output logic [6:0] hp_p1,
    output logic [6:0] hp_p2,
    output logic       ko_valid,
    output logic [1:0] winner,
    output logic       in_bar,
    output logic       bar_sel,
    output logic [3:0] spr_row,
    output logic [7:0] spr_col,
    output logic       fill_on
);

    localparam logic [6:0] HP_MAX_C = 7'(HP_MAX);
    localparam logic [6:0] DMG_C    = 7'(DMG);
    localparam logic [6:0] FILL_C   = 7'(FILL_STP);
    localparam logic [6:0] DRN_C    = 7'(DRN_STP);

    // Bar rectangles: 144 wide by 12 high, inclusive bounds.
    localparam logic [9:0] P1_L = 10'(P1_X);
    localparam logic [9:0] P1_R = 10'(P1_X + 143);
    localparam logic [9:0] P2_L = 10'(P2_X);
    localparam logic [9:0] P2_R = 10'(P2_X + 143);
    localparam logic [9:0] Y_T  = 10'(BAR_Y);
    localparam logic [9:0] Y_B  = 10'(BAR_Y + 11);

    // Fill window: dive grows right from column 36, kick grows left ending at column 103.
    localparam logic [8:0] DIVE_ORG = 9'd36;
    localparam logic [8:0] KICK_END = 9'd104;
    localparam logic [3:0] ROW_LO   = 4'd2;
    localparam logic [3:0] ROW_HI   = 4'd9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FIGHT = 3'd2,
        DRAIN = 3'd3,
        KO    = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] hp_p1_q, hp_p1_d, hp_p2_q, hp_p2_d;
    logic [6:0] disp_p1_q, disp_p1_d, disp_p2_q, disp_p2_d;
    logic       ack_p1_q, ack_p1_d, ack_p2_q, ack_p2_d;
    logic       ko_valid_q, ko_valid_d;
    logic [1:0] winner_q, winner_d;
    logic       p1_dead_s, p2_dead_s;

    logic       in_bar_q, in_bar_d;
    logic       bar_sel_q, bar_sel_d;
    logic [3:0] spr_row_q, spr_row_d;
    logic [7:0] spr_col_q, spr_col_d;
    logic       fill_on_q, fill_on_d;

    logic       row_hit_s, in_p1_s, in_p2_s, dive_s, kick_s;
    logic [3:0] row_s;
    logic [7:0] col_s;
    logic [8:0] col9_s;

    // Saturating add that never exceeds ceil.
    function automatic logic [6:0] sat_add(input logic [6:0] val, input logic [6:0] step,
                                           input logic [6:0] ceil);
        logic [7:0] sum;
        sum = {1'b0, val} + {1'b0, step};
        if (sum >= {1'b0, ceil}) begin
            sat_add = ceil;
        end else begin
            sat_add = sum[6:0];
        end
    endfunction

    // Saturating subtract that never goes below floor (and never wraps).
    function automatic logic [6:0] sat_sub(input logic [6:0] val, input logic [6:0] step,
                                           input logic [6:0] floor);
        if (val <= floor) begin
            sat_sub = val;
        end else if ((val - floor) > step) begin
            sat_sub = val - step;
        end else begin
            sat_sub = floor;
        end
    endfunction

    // Round sequencer: next state, HP, displayed fill, acks and winner.
    always_comb begin
        state_d   = state_q;
        hp_p1_d   = hp_p1_q;
        hp_p2_d   = hp_p2_q;
        disp_p1_d = disp_p1_q;
        disp_p2_d = disp_p2_q;
        ack_p1_d  = 1'b0;
        ack_p2_d  = 1'b0;
        winner_d  = winner_q;
        p1_dead_s = 1'b0;
        p2_dead_s = 1'b0;
        if (round_start) begin
            // A new round overrides everything, including a same-cycle hit.
            state_d   = FILL;
            hp_p1_d   = HP_MAX_C;
            hp_p2_d   = HP_MAX_C;
            disp_p1_d = 7'd0;
            disp_p2_d = 7'd0;
            winner_d  = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FILL: begin
                    disp_p1_d = frame_tick ? sat_add(disp_p1_q, FILL_C, HP_MAX_C) : disp_p1_q;
                    disp_p2_d = frame_tick ? sat_add(disp_p2_q, FILL_C, HP_MAX_C) : disp_p2_q;
                    state_d   = (frame_tick && (disp_p1_d == HP_MAX_C) && (disp_p2_d == HP_MAX_C))
                                ? FIGHT : FILL;
                end
                FIGHT: begin
                    hp_p1_d   = hit_p1 ? sat_sub(hp_p1_q, DMG_C, 7'd0) : hp_p1_q;
                    hp_p2_d   = hit_p2 ? sat_sub(hp_p2_q, DMG_C, 7'd0) : hp_p2_q;
                    ack_p1_d  = hit_p1;
                    ack_p2_d  = hit_p2;
                    disp_p1_d = frame_tick ? sat_sub(disp_p1_q, DRN_C, hp_p1_d) : disp_p1_q;
                    disp_p2_d = frame_tick ? sat_sub(disp_p2_q, DRN_C, hp_p2_d) : disp_p2_q;
                    p1_dead_s = (hp_p1_d == 7'd0);
                    p2_dead_s = (hp_p2_d == 7'd0);
                    // Winner bits: bit1 set when P1 is down, bit0 set when P2 is down.
                    state_d   = (p1_dead_s || p2_dead_s) ? DRAIN : FIGHT;
                    winner_d  = (p1_dead_s || p2_dead_s) ? {p1_dead_s, p2_dead_s} : winner_q;
                end
                DRAIN: begin
                    disp_p1_d = frame_tick ? sat_sub(disp_p1_q, DRN_C, hp_p1_q) : disp_p1_q;
                    disp_p2_d = frame_tick ? sat_sub(disp_p2_q, DRN_C, hp_p2_q) : disp_p2_q;
                    state_d   = (frame_tick && (disp_p1_d == hp_p1_q) && (disp_p2_d == hp_p2_q))
                                ? KO : DRAIN;
                end
                KO: begin
                    state_d = KO;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        ko_valid_d = (state_d == KO);
    end

    // Sequencer state and registered round outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            hp_p1_q    <= 7'd0;
            hp_p2_q    <= 7'd0;
            disp_p1_q  <= 7'd0;
            disp_p2_q  <= 7'd0;
            ack_p1_q   <= 1'b0;
            ack_p2_q   <= 1'b0;
            ko_valid_q <= 1'b0;
            winner_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            hp_p1_q    <= hp_p1_d;
            hp_p2_q    <= hp_p2_d;
            disp_p1_q  <= disp_p1_d;
            disp_p2_q  <= disp_p2_d;
            ack_p1_q   <= ack_p1_d;
            ack_p2_q   <= ack_p2_d;
            ko_valid_q <= ko_valid_d;
            winner_q   <= winner_d;
        end
    end

    // Pixel map: bar hit test, sprite coordinates and fill window.
    always_comb begin
        row_hit_s = (DrawY >= Y_T) && (DrawY <= Y_B);
        in_p1_s   = row_hit_s && (DrawX >= P1_L) && (DrawX <= P1_R);
        in_p2_s   = row_hit_s && (DrawX >= P2_L) && (DrawX <= P2_R);
        row_s     = 4'(DrawY - Y_T);
        col_s     = in_p2_s ? 8'(DrawX - P2_L) : 8'(DrawX - P1_L);
        col9_s    = {1'b0, col_s};
        dive_s    = (col9_s >= DIVE_ORG) && (col9_s < (DIVE_ORG + {2'b00, disp_p1_q}));
        kick_s    = (col9_s < KICK_END) && ((col9_s + {2'b00, disp_p2_q}) >= KICK_END);
        in_bar_d  = in_p1_s || in_p2_s;
        bar_sel_d = in_p2_s;
        spr_row_d = in_bar_d ? row_s : 4'd0;
        spr_col_d = in_bar_d ? col_s : 8'd0;
        fill_on_d = in_bar_d && (row_s >= ROW_LO) && (row_s <= ROW_HI)
                    && (in_p2_s ? kick_s : dive_s);
    end

    // Pixel outputs, one cycle behind DrawX/DrawY.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            in_bar_q  <= 1'b0;
            bar_sel_q <= 1'b0;
            spr_row_q <= 4'd0;
            spr_col_q <= 8'd0;
            fill_on_q <= 1'b0;
        end else begin
            in_bar_q  <= in_bar_d;
            bar_sel_q <= bar_sel_d;
            spr_row_q <= spr_row_d;
            spr_col_q <= spr_col_d;
            fill_on_q <= fill_on_d;
        end
    end

    assign hit_ack_p1 = ack_p1_q;
    assign hit_ack_p2 = ack_p2_q;
    assign hp_p1      = hp_p1_q;
    assign hp_p2      = hp_p2_q;
    assign ko_valid   = ko_valid_q;
    assign winner     = winner_q;
    assign in_bar     = in_bar_q;
    assign bar_sel    = bar_sel_q;
    assign spr_row    = spr_row_q;
    assign spr_col    = spr_col_q;
    assign fill_on    = fill_on_q;

endmodule

// File: tb/tb_health_bar_ctrl.sv
// Directed bench for health_bar_ctrl: pixel-map vector table plus round sequences.
module tb_health_bar_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick, round_start, hit_p1, hit_p2;
    logic [9:0] DrawX, DrawY;
    logic       hit_ack_p1, hit_ack_p2, ko_valid, in_bar, bar_sel, fill_on;
    logic [6:0] hp_p1, hp_p2;
    logic [1:0] winner;
    logic [3:0] spr_row;
    logic [7:0] spr_col;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       in_bar;
        logic       sel;
        logic [3:0] row;
        logic [7:0] col;
        logic       fill;
    } pix_vec_t;

    pix_vec_t vecs[$];

    health_bar_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .round_start(round_start),
        .hit_p1(hit_p1), .hit_p2(hit_p2), .DrawX(DrawX), .DrawY(DrawY),
        .hit_ack_p1(hit_ack_p1), .hit_ack_p2(hit_ack_p2), .hp_p1(hp_p1), .hp_p2(hp_p2),
        .ko_valid(ko_valid), .winner(winner), .in_bar(in_bar), .bar_sel(bar_sel),
        .spr_row(spr_row), .spr_col(spr_col), .fill_on(fill_on)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
        end
    endtask

    task automatic start_round();
        round_start = 1'b1;
        cyc(1);
        round_start = 1'b0;
    endtask

    task automatic hit(input logic h1, input logic h2);
        hit_p1 = h1;
        hit_p2 = h2;
        cyc(1);
        hit_p1 = 1'b0;
        hit_p2 = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack1"}, int'(hit_ack_p1), 0);
        check({tag, "_ack2"}, int'(hit_ack_p2), 0);
        check({tag, "_hp1"}, int'(hp_p1), 0);
        check({tag, "_hp2"}, int'(hp_p2), 0);
        check({tag, "_ko"}, int'(ko_valid), 0);
        check({tag, "_winner"}, int'(winner), 0);
        check({tag, "_in_bar"}, int'(in_bar), 0);
        check({tag, "_bar_sel"}, int'(bar_sel), 0);
        check({tag, "_row"}, int'(spr_row), 0);
        check({tag, "_col"}, int'(spr_col), 0);
        check({tag, "_fill"}, int'(fill_on), 0);
    endtask

    task automatic pix(input string tag, input int x, input int y, input int exp_fill);
        DrawX = 10'(x);
        DrawY = 10'(y);
        cyc(1);
        check(tag, int'(fill_on), exp_fill);
    endtask

    initial begin
        // Expected pixel map with both displayed fills at 100.
        vecs.push_back('{10'd52,  10'd21, 1'b1, 1'b0, 4'd5,  8'd36,  1'b1});
        vecs.push_back('{10'd51,  10'd21, 1'b1, 1'b0, 4'd5,  8'd35,  1'b0});
        vecs.push_back('{10'd151, 10'd21, 1'b1, 1'b0, 4'd5,  8'd135, 1'b1});
        vecs.push_back('{10'd152, 10'd21, 1'b1, 1'b0, 4'd5,  8'd136, 1'b0});
        vecs.push_back('{10'd16,  10'd16, 1'b1, 1'b0, 4'd0,  8'd0,   1'b0});
        vecs.push_back('{10'd159, 10'd27, 1'b1, 1'b0, 4'd11, 8'd143, 1'b0});
        vecs.push_back('{10'd160, 10'd21, 1'b0, 1'b0, 4'd0,  8'd0,   1'b0});
        vecs.push_back('{10'd15,  10'd21, 1'b0, 1'b0, 4'd0,  8'd0,   1'b0});
        vecs.push_back('{10'd52,  10'd15, 1'b0, 1'b0, 4'd0,  8'd0,   1'b0});
        vecs.push_back('{10'd52,  10'd28, 1'b0, 1'b0, 4'd0,  8'd0,   1'b0});
        vecs.push_back('{10'd52,  10'd18, 1'b1, 1'b0, 4'd2,  8'd36,  1'b1});
        vecs.push_back('{10'd52,  10'd25, 1'b1, 1'b0, 4'd9,  8'd36,  1'b1});
        vecs.push_back('{10'd52,  10'd26, 1'b1, 1'b0, 4'd10, 8'd36,  1'b0});
        vecs.push_back('{10'd52,  10'd17, 1'b1, 1'b0, 4'd1,  8'd36,  1'b0});
        vecs.push_back('{10'd484, 10'd21, 1'b1, 1'b1, 4'd5,  8'd4,   1'b1});
        vecs.push_back('{10'd483, 10'd21, 1'b1, 1'b1, 4'd5,  8'd3,   1'b0});
        vecs.push_back('{10'd583, 10'd21, 1'b1, 1'b1, 4'd5,  8'd103, 1'b1});
        vecs.push_back('{10'd584, 10'd21, 1'b1, 1'b1, 4'd5,  8'd104, 1'b0});
        vecs.push_back('{10'd623, 10'd27, 1'b1, 1'b1, 4'd11, 8'd143, 1'b0});
        vecs.push_back('{10'd624, 10'd21, 1'b0, 1'b0, 4'd0,  8'd0,   1'b0});
        vecs.push_back('{10'd479, 10'd21, 1'b0, 1'b0, 4'd0,  8'd0,   1'b0});

        Reset = 1'b1;
        frame_tick = 1'b0; round_start = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0;
        cyc(2);
        check_all_zero("reset");
        Reset = 1'b0;

        // Before any round the bars are empty.
        pix("idle_dive_fill", 52, 21, 0);
        check("idle_in_bar", int'(in_bar), 1);
        pix("idle_kick_fill", 583, 21, 0);
        // Hits while idle are ignored.
        hit(1'b1, 1'b0);
        check("idle_hit_ack", int'(hit_ack_p1), 0);
        check("idle_hit_hp", int'(hp_p1), 0);

        start_round();
        check("start_hp1", int'(hp_p1), 100);
        check("start_hp2", int'(hp_p2), 100);
        check("start_ko", int'(ko_valid), 0);
        check("start_winner", int'(winner), 0);

        // Hits during FILL are ignored and never acknowledged.
        hit(1'b0, 1'b1);
        check("fill_hit_ack2", int'(hit_ack_p2), 0);
        check("fill_hit_hp2", int'(hp_p2), 100);
        ticks(49);
        hit(1'b1, 1'b0);
        check("fill49_hit_ack1", int'(hit_ack_p1), 0);
        check("fill49_hit_hp1", int'(hp_p1), 100);
        ticks(1);

        // Pixel table with both bars full.
        foreach (vecs[i]) begin
            DrawX = vecs[i].x;
            DrawY = vecs[i].y;
            cyc(1);
            check($sformatf("pix%0d_in_bar", i), int'(in_bar), int'(vecs[i].in_bar));
            check($sformatf("pix%0d_sel", i), int'(bar_sel), int'(vecs[i].sel));
            check($sformatf("pix%0d_row", i), int'(spr_row), int'(vecs[i].row));
            check($sformatf("pix%0d_col", i), int'(spr_col), int'(vecs[i].col));
            check($sformatf("pix%0d_fill", i), int'(fill_on), int'(vecs[i].fill));
        end

        // Two hits on P1 in FIGHT, each acknowledged one cycle later.
        hit(1'b1, 1'b0);
        check("fight_hit1_hp1", int'(hp_p1), 75);
        check("fight_hit1_ack1", int'(hit_ack_p1), 1);
        check("fight_hit1_ack2", int'(hit_ack_p2), 0);
        cyc(1);
        check("fight_ack1_drop", int'(hit_ack_p1), 0);
        hit(1'b1, 1'b0);
        check("fight_hit2_hp1", int'(hp_p1), 50);
        check("fight_hit2_ack1", int'(hit_ack_p1), 1);
        check("fight_hit2_hp2", int'(hp_p2), 100);

        // Displayed fill drains one pixel per tick down to HP.
        DrawX = 10'd102; DrawY = 10'd21;
        ticks(49);
        cyc(1);
        check("drain49_col86", int'(fill_on), 1);
        ticks(1);
        cyc(1);
        check("drain50_col86", int'(fill_on), 0);
        pix("drain50_col85", 101, 21, 1);
        ticks(1);
        cyc(1);
        check("drain_floor_col85", int'(fill_on), 1);
        check("fight_ko", int'(ko_valid), 0);
        check("fight_winner", int'(winner), 0);

        // round_start together with a hit: restart wins, no ack.
        round_start = 1'b1;
        hit_p2 = 1'b1;
        cyc(1);
        round_start = 1'b0;
        hit_p2 = 1'b0;
        check("restart_ack2", int'(hit_ack_p2), 0);
        check("restart_hp1", int'(hp_p1), 100);
        check("restart_hp2", int'(hp_p2), 100);
        ticks(50);

        // Simultaneous hits four times -> double KO.
        for (int k = 1; k <= 4; k++) begin
            hit(1'b1, 1'b1);
            check($sformatf("dbl%0d_hp1", k), int'(hp_p1), 100 - 25 * k);
            check($sformatf("dbl%0d_hp2", k), int'(hp_p2), 100 - 25 * k);
            check($sformatf("dbl%0d_ack1", k), int'(hit_ack_p1), 1);
            check($sformatf("dbl%0d_ack2", k), int'(hit_ack_p2), 1);
        end
        check("dbl_winner", int'(winner), 3);
        check("dbl_ko_early", int'(ko_valid), 0);
        hit(1'b1, 1'b0);
        check("drain_hit_ack1", int'(hit_ack_p1), 0);
        check("drain_hit_hp1", int'(hp_p1), 0);
        ticks(99);
        check("dbl_ko_99", int'(ko_valid), 0);
        ticks(1);
        check("dbl_ko_100", int'(ko_valid), 1);
        check("dbl_ko_winner", int'(winner), 3);
        pix("ko_dive_empty", 52, 21, 0);
        pix("ko_kick_empty", 583, 21, 0);

        // P1 knocked out, then reset asserted mid-DRAIN.
        start_round();
        check("r3_ko_clear", int'(ko_valid), 0);
        check("r3_winner_clear", int'(winner), 0);
        ticks(50);
        for (int k = 1; k <= 4; k++) begin
            hit(1'b1, 1'b0);
        end
        check("p1ko_hp1", int'(hp_p1), 0);
        check("p1ko_hp2", int'(hp_p2), 100);
        check("p1ko_winner", int'(winner), 2);
        DrawX = 10'd52; DrawY = 10'd21;
        ticks(3);
        check("p1ko_in_bar", int'(in_bar), 1);
        check("p1ko_ko", int'(ko_valid), 0);
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        cyc(1);
        Reset = 1'b0;
        hit(1'b1, 1'b1);
        check("post_reset_ack1", int'(hit_ack_p1), 0);
        check("post_reset_hp1", int'(hp_p1), 0);
        check("post_reset_ko", int'(ko_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
